// File: rtl/buyruk_on_getir.sv
// Instruction prefetch queue: fetches sequential words from L1 instruction memory into a small FIFO for decode.
// Latency: a response accepted while l1b_bekle_i is low appears on cyo_* next cycle; one request in flight at a time.
// Backpressure: a new request is issued only if the queue has room; decode pops with cyo_al_i; a redirect flushes the queue.
module buyruk_on_getir #(
  parameter int unsigned DERINLIK     = 4,
  parameter logic [31:0] BASLANGIC_PS = 32'h4000_0000
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       l1b_bekle_i,
  input  logic [31:0]                l1b_deger_i,
  output logic                       l1b_chip_select_n_o,
  output logic [31:0]                l1b_adres_o,
  input  logic                       yrt_atlanan_ps_gecerli_i,
  input  logic [30:0]                yrt_atlanan_ps_i,
  output logic [31:0]                cyo_buyruk_o,
  output logic [30:0]                cyo_ps_o,
  output logic                       cyo_gecerli_o,
  input  logic                       cyo_al_i,
  output logic [$clog2(DERINLIK):0]  doluluk_o
);

  localparam int unsigned PW = $clog2(DERINLIK);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DOLU = CW'(DERINLIK);

  typedef enum logic [1:0] {
    BOSTA = 2'd0,
    ISTEK = 2'd1,
    IPTAL = 2'd2
  } durum_t;

  durum_t        durum;
  durum_t        durum_sonraki;

  logic [31:0]   buyruk_mem [DERINLIK];
  logic [30:0]   ps_mem     [DERINLIK];
  logic [PW-1:0] oku_ptr;
  logic [PW-1:0] yaz_ptr;
  logic [CW-1:0] sayac;
  logic [CW-1:0] sayac_sonraki;

  // getir_ps: next PC to fetch; istek_ps: PC of the request currently on the L1 port
  logic [30:0]   getir_ps;
  logic [30:0]   getir_ps_sonraki;
  logic [30:0]   istek_ps;

  logic          yonlendir;
  logic          ekle;
  logic          cikar;
  logic          yeni_istek;

  // A redirect overrides everything: no push, no pop, queue emptied
  assign yonlendir     = yrt_atlanan_ps_gecerli_i;
  assign ekle          = (durum == ISTEK) && !l1b_bekle_i && !yonlendir;
  assign cikar         = cyo_al_i && (sayac != '0) && !yonlendir;
  assign sayac_sonraki = yonlendir ? '0 : (sayac + CW'(ekle) - CW'(cikar));

  // Fetch PC after this edge: redirect target, else the word after the one just pushed
  assign getir_ps_sonraki = yonlendir ? yrt_atlanan_ps_i :
                            ekle      ? (istek_ps + 31'd2) : getir_ps;

  // A fresh request starts next cycle whenever we enter ISTEK from idle or after a response
  assign yeni_istek = (durum_sonraki == ISTEK) && ((durum == BOSTA) || !l1b_bekle_i);

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) durum <= BOSTA;
    else        durum <= durum_sonraki;
  end

  // Next-state decision; issue only while the queue will have room after this edge
  always_comb begin
    durum_sonraki = durum;
    unique case (durum)
      BOSTA: begin
        if (sayac_sonraki < DOLU) durum_sonraki = ISTEK;
      end
      ISTEK: begin
        if (yonlendir)         durum_sonraki = l1b_bekle_i ? IPTAL : ISTEK;
        else if (!l1b_bekle_i) durum_sonraki = (sayac_sonraki < DOLU) ? ISTEK : BOSTA;
      end
      IPTAL: begin
        if (!l1b_bekle_i) durum_sonraki = ISTEK;
      end
      default: durum_sonraki = BOSTA;
    endcase
  end

  // Chip select decoded from the state register alone
  always_comb begin
    l1b_chip_select_n_o = 1'b1;
    if ((durum == ISTEK) || (durum == IPTAL)) l1b_chip_select_n_o = 1'b0;
  end

  // Fetch PC and request address; istek_ps only moves when a new request begins, so it holds during waits
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      getir_ps <= BASLANGIC_PS[31:1];
      istek_ps <= BASLANGIC_PS[31:1];
    end else begin
      getir_ps <= getir_ps_sonraki;
      if (yeni_istek) istek_ps <= getir_ps_sonraki;
    end
  end

  // Queue occupancy and wrap-around pointers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sayac   <= '0;
      oku_ptr <= '0;
      yaz_ptr <= '0;
    end else begin
      sayac <= sayac_sonraki;
      if (yonlendir) begin
        oku_ptr <= '0;
        yaz_ptr <= '0;
      end else begin
        if (ekle)  yaz_ptr <= yaz_ptr + PW'(1);
        if (cikar) oku_ptr <= oku_ptr + PW'(1);
      end
    end
  end

  // Queue storage; contents need no reset since the count gates visibility
  always_ff @(posedge clk_i) begin
    if (ekle) begin
      buyruk_mem[yaz_ptr] <= l1b_deger_i;
      ps_mem[yaz_ptr]     <= istek_ps;
    end
  end

  assign l1b_adres_o   = {istek_ps, 1'b0};
  assign cyo_buyruk_o  = buyruk_mem[oku_ptr];
  assign cyo_ps_o      = ps_mem[oku_ptr];
  assign cyo_gecerli_o = (sayac != '0);
  assign doluluk_o     = sayac;

endmodule
